ahb_mem_subordinate: RTL and testbench
======================================

// Module: ahb_mem_subordinate
// PURPOSE
//  Parametrised AHB5 subordinate memory model for the VIP testbench; it is the responder paired with the AHB interface.
//  Provides a word-addressed RAM with byte strobes, configurable wait states and a two-cycle ERROR response.
//  Sits behind the decoder (HSELx) and drives HRDATA/HREADYOUT/HRESP back to the manager mux.
// PARAMETERS
//  ADDR_WIDTH   32    HADDR width
//  DATA_WIDTH   32    HRDATA/HWDATA width; one of 32, 64, 128
//  MEM_DEPTH    1024  number of DATA_WIDTH words; byte address limit = MEM_DEPTH*DATA_WIDTH/8
//  WAIT_STATES  0     HREADYOUT-low cycles inserted per OKAY data phase (0..15)
//  ERR_ADDR_LO  'hFFFF_0000  start of the forced-ERROR byte-address window (inclusive)
//  ERR_ADDR_HI  'hFFFF_FFFF  end of the forced-ERROR byte-address window (inclusive)
// PORTS
//  HCLK       in   1             clock, rising edge
//  HRESETn    in   1             reset, asynchronous assert, active-low
//  HSELx      in   1             subordinate select
//  HADDR      in   ADDR_WIDTH    byte address
//  HTRANS     in   2             0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  HWRITE     in   1             1 = write
//  HSIZE      in   3             transfer size, log2(bytes)
//  HBURST     in   3             burst type; ignored, every beat carries its own address
//  HPROT      in   4             ignored
//  HMASTLOCK  in   1             ignored
//  HWDATA     in   DATA_WIDTH    write data (data phase)
//  HWSTRB     in   DATA_WIDTH/8  write byte strobes (data phase)
//  HREADY     in   1             bus-level ready from the interconnect
//  HRDATA     out  DATA_WIDTH    read data
//  HREADYOUT  out  1             this subordinate's ready
//  HRESP      out  1             0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset: async on HRESETn=0; HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
//   RAM contents are not reset. Reset mid-transfer aborts the transfer and discards any pending write.
//  Address phase accepted on a rising edge with HSELx & HREADY & HTRANS[1].
//   Captured at acceptance: HADDR, HWRITE, HSIZE.
//   IDLE/BUSY with HSELx=1 (or HSELx=0) -> zero-wait OKAY; no access.
//  Error check, evaluated at acceptance; any true -> ERROR:
//   - address >= MEM_DEPTH*DATA_WIDTH/8
//   - ERR_ADDR_LO <= address <= ERR_ADDR_HI
//   - 2**HSIZE > DATA_WIDTH/8
//   - address not aligned to 2**HSIZE
//  FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
//   IDLE: accept with error -> ERR1.
//         accept OKAY with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1.
//         accept OKAY with WAIT_STATES=0 -> LAST.
//   WAIT: HREADYOUT=0, HRESP=0; counter decrements; at 0 -> LAST.
//   LAST: final data-phase cycle; HREADYOUT=1, HRESP=0; write committed on this edge.
//         Same edge may accept the next address phase (pipelined): -> WAIT, LAST or ERR1, else IDLE.
//   ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
//   ERR2: HREADYOUT=1, HRESP=1; no RAM access; new acceptance allowed per the IDLE rules.
//   No wait states are ever inserted on ERROR.
//  Latency: zero-wait OKAY completes 1 cycle after the address phase; with N wait states, N+1 cycles.
//  Write: byte lane i written iff HWSTRB[i] & lane i is within the (addr, size) window; other lanes unchanged.
//  Read: HRDATA = RAM word at the captured address while in LAST for a read, else 0.
//   All lanes driven; lanes outside the size window are don't-care to the manager.
//  Back-to-back write then read to the same word: the read returns the new data (write commits before the read's LAST).
//  Address wrap: none; the index is addr[log2(MEM_DEPTH*DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; out-of-range addresses error.
// TESTING
//  1. Reset: HRESETn low mid-WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the pending write is not committed.
//  2. WAIT_STATES=0: NONSEQ write 0x10=0xDEADBEEF, HWSTRB=4'hF, then read 0x10 -> HRDATA=0xDEADBEEF,
//     each transfer 1 cycle, HRESP=0.
//  3. Byte write: HSIZE=0, addr 0x12, HWDATA=0x00AB0000, HWSTRB=4'h4 over 0xDEADBEEF ->
//     read 0x10 returns 0xDEABBEEF.
//  4. WAIT_STATES=3: NONSEQ read -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data;
//     an IDLE transfer gets zero-wait OKAY.
//  5. ERROR: read at MEM_DEPTH*4 and a misaligned word access (addr 0x2, HSIZE=2) ->
//     (HREADYOUT,HRESP) = (0,1) then (1,1); RAM unchanged.
//  6. 4-beat INCR SEQ burst writes 0x20..0x2C, then read back -> all 4 words match;
//     BUSY mid-burst gives OKAY with no access.

Source files
------------

// File: rtl/ahb_mem_subordinate_if.sv
// AHB5 subordinate-side bus bundle: manager-driven request/data and subordinate response.
// Latency: none, wires only.
// Backpressure: carries HREADY (interconnect) and HREADYOUT (subordinate) handshake.
interface ahb_mem_subordinate_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    HSELx;
   logic [ADDR_WIDTH-1:0]   HADDR;
   logic [1:0]              HTRANS;
   logic                    HWRITE;
   logic [2:0]              HSIZE;
   logic [2:0]              HBURST;
   logic [3:0]              HPROT;
   logic                    HMASTLOCK;
   logic [DATA_WIDTH-1:0]   HWDATA;
   logic [DATA_WIDTH/8-1:0] HWSTRB;
   logic                    HREADY;
   logic [DATA_WIDTH-1:0]   HRDATA;
   logic                    HREADYOUT;
   logic                    HRESP;

   modport master (
      output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
             HWDATA, HWSTRB, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
             HWDATA, HWSTRB, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_mem_subordinate.sv
// AHB5 subordinate RAM with byte strobes, configurable wait states and two-cycle ERROR.
// Latency: OKAY completes WAIT_STATES+1 cycles after address acceptance; ERROR takes 2 cycles.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle; no internal buffering.
module ahb_mem_subordinate #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 1024,
   parameter int                    WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_LO = 'hFFFF_0000,
   parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_HI = 'hFFFF_FFFF
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_mem_subordinate_if.slave bus
);
   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int BL        = $clog2(BYTES);
   localparam int MEM_BYTES = MEM_DEPTH * BYTES;
   localparam int IW        = $clog2(MEM_BYTES);
   localparam int XW        = IW - BL;

   typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic [XW-1:0]         r_idx;
   logic [BL-1:0]         r_off;
   logic [2:0]            r_size;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic                  w_accept;
   logic                  w_oob;
   logic                  w_win;
   logic                  w_big;
   logic                  w_misalign;
   logic                  w_err;
   logic                  w_readyout;
   logic                  w_resp;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [BYTES-1:0]      w_lane;
   logic                  w_unused;

   // Only states whose cycle ends with HREADYOUT high can take a new address phase.
   assign w_accept = bus.HSELx & bus.HREADY & bus.HTRANS[1] &
                     ((r_state == IDLE) | (r_state == LAST) | (r_state == ERR2));

   assign w_oob      = (64'(bus.HADDR) >= 64'(MEM_BYTES));
   // Offset-from-LO compare keeps the window check free of constant-bound comparisons.
   assign w_win      = ((bus.HADDR - ERR_ADDR_LO) <= (ERR_ADDR_HI - ERR_ADDR_LO));
   assign w_big      = (bus.HSIZE > 3'(BL));
   assign w_misalign = |(bus.HADDR[6:0] & ((7'd1 << bus.HSIZE) - 7'd1));
   assign w_err      = w_oob | w_win | w_big | w_misalign;

   // Burst type, protection, lock and the IDLE/BUSY distinction do not affect this memory.
   assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

   // State, wait counter and captured address-phase controls.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_off   <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_idx   <= bus.HADDR[IW-1:BL];
            r_off   <= bus.HADDR[BL-1:0];
            r_size  <= bus.HSIZE;
            r_write <= bus.HWRITE;
         end
      end
   end

   // Next state and the HREADYOUT/HRESP response for the current data-phase cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_readyout  = 1'b1;
      w_resp      = 1'b0;
      case (r_state)
         IDLE, LAST: w_state_nxt = IDLE;
         WAIT: begin
            w_readyout = 1'b0;
            if (r_cnt == 4'd0) w_state_nxt = LAST;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         ERR1: begin
            w_readyout  = 1'b0;
            w_resp      = 1'b1;
            w_state_nxt = ERR2;
         end
         ERR2: begin
            w_resp      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_accept) begin
         if (w_err) begin
            w_state_nxt = ERR1;
         end else if (WAIT_STATES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
         end else begin
            w_state_nxt = LAST;
         end
      end
   end

   // Byte lanes covered by the captured (offset, size) window.
   always_comb begin
      w_lane = '0;
      for (int i = 0; i < BYTES; i++) begin
         w_lane[i] = ((i >> r_size) == (int'(r_off) >> r_size));
      end
   end

   // Write commits on the edge closing the final data-phase cycle, so a following read sees it.
   always_ff @(posedge HCLK) begin
      if (r_state == LAST && r_write) begin
         for (int i = 0; i < BYTES; i++) begin
            if (w_lane[i] & bus.HWSTRB[i]) r_mem[r_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

   // Read data is only presented in the final cycle of a read; zero otherwise.
   always_comb begin
      w_rdata = '0;
      if (r_state == LAST && !r_write) w_rdata = r_mem[r_idx];
   end

   assign bus.HRDATA    = w_rdata;
   assign bus.HREADYOUT = w_readyout;
   assign bus.HRESP     = w_resp;
endmodule

// File: tb/tb_ahb_mem_subordinate.sv
// Bench for ahb_mem_subordinate: a zero-wait and a three-wait instance share one driver.
// A byte-level memory model predicts every data-phase cycle; literal checks pin the model.
module tb_ahb_mem_subordinate;
   localparam int MEM_BYTES = 4096;

   typedef struct packed {
      logic [1:0]  tr;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } xfer_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        d_sel, d_hsel, d_wr;
   logic [1:0]  d_trans;
   logic [31:0] d_addr, d_wdata;
   logic [2:0]  d_size;
   logic [3:0]  d_strb;

   ahb_mem_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ahb_mem_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   assign bus0.HSELx = d_hsel & ~d_sel;
   assign bus1.HSELx = d_hsel & d_sel;
   assign bus0.HADDR = d_addr;    assign bus1.HADDR = d_addr;
   assign bus0.HTRANS = d_trans;  assign bus1.HTRANS = d_trans;
   assign bus0.HWRITE = d_wr;     assign bus1.HWRITE = d_wr;
   assign bus0.HSIZE = d_size;    assign bus1.HSIZE = d_size;
   assign bus0.HBURST = 3'b001;   assign bus1.HBURST = 3'b001;
   assign bus0.HPROT = 4'b0011;   assign bus1.HPROT = 4'b0011;
   assign bus0.HMASTLOCK = 1'b0;  assign bus1.HMASTLOCK = 1'b0;
   assign bus0.HWDATA = d_wdata;  assign bus1.HWDATA = d_wdata;
   assign bus0.HWSTRB = d_strb;   assign bus1.HWSTRB = d_strb;
   assign bus0.HREADY = bus0.HREADYOUT;
   assign bus1.HREADY = bus1.HREADYOUT;

   ahb_mem_subordinate #(.WAIT_STATES(0)) dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(bus0));
   ahb_mem_subordinate #(.WAIT_STATES(3)) dut1 (.HCLK(clk), .HRESETn(rst_n), .bus(bus1));

   logic        obs_rdy, obs_resp;
   logic [31:0] obs_rdata;
   assign obs_rdy   = d_sel ? bus1.HREADYOUT : bus0.HREADYOUT;
   assign obs_resp  = d_sel ? bus1.HRESP     : bus0.HRESP;
   assign obs_rdata = d_sel ? bus1.HRDATA    : bus0.HRDATA;

   // Byte-addressed reference memories, one per instance.
   logic [7:0] mb [2][MEM_BYTES];

   function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
      bit e = 1'b0;
      if ({32'd0, a} >= 64'(MEM_BYTES)) e = 1'b1;
      if ({32'd0, a} >= 64'h0000_0000_FFFF_0000 && {32'd0, a} <= 64'h0000_0000_FFFF_FFFF) e = 1'b1;
      if ((32'd1 << sz) > 32'd4) e = 1'b1;
      if ((a % (32'd1 << sz)) != 32'd0) e = 1'b1;
      return e;
   endfunction

   function automatic int plen(input int s, input xfer_t x);
      if (!x.tr[1]) return 1;
      if (m_err(x.addr, x.size)) return 2;
      return (s != 0) ? 4 : 1;
   endfunction

   function automatic logic [31:0] m_word(input int s, input logic [31:0] a);
      int base = int'(a) & ~3;
      return {mb[s][base+3], mb[s][base+2], mb[s][base+1], mb[s][base]};
   endfunction

   function automatic logic [31:0] m_mask(input logic [31:0] a, input logic [2:0] sz);
      logic [31:0] m = '0;
      for (int b = int'(a); b < int'(a) + (1 << sz); b++) m[8*(b % 4) +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic m_write(input int s, input xfer_t x);
      for (int b = int'(x.addr); b < int'(x.addr) + (1 << x.size); b++) begin
         if (x.strb[b % 4]) mb[s][b] = x.wdata[8*(b % 4) +: 8];
      end
   endtask

   // Expectations for the current cycle, owned by the driver.
   logic        chk_en = 1'b0;
   logic        need_rdy, need_resp;
   logic [31:0] need_rdata, need_mask;
   logic        lit_req = 1'b0;
   string       lit_name;
   logic [31:0] lit_act, lit_need;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;

   // Single compare process: per-cycle model check plus queued literal checks.
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         n_chk++;
         if (obs_rdy !== need_rdy || obs_resp !== need_resp ||
             (obs_rdata & need_mask) !== (need_rdata & need_mask)) begin
            n_fail++;
            $display("FAIL bus-cycle %0d: got rdy=%b resp=%b rdata=%h, required rdy=%b resp=%b rdata=%h (mask %h)",
                     cyc, obs_rdy, obs_resp, obs_rdata, need_rdy, need_resp, need_rdata, need_mask);
         end
      end
      if (lit_req) begin
         n_chk++;
         if (lit_act !== lit_need) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", lit_name, lit_act, lit_need);
         end
      end
   end

   task automatic lit_check(input string nm, input logic [31:0] act, input logic [31:0] want);
      lit_name = nm; lit_act = act; lit_need = want; lit_req = 1'b1;
      @(negedge clk); #1 lit_req = 1'b0;
      @(posedge clk); #1;
   endtask

   xfer_t seq[$];
   int          seq_low;
   logic [31:0] seq_rdata_last;

   task automatic push(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st);
      xfer_t x;
      x.tr = tr; x.addr = a; x.wr = wr; x.size = sz; x.wdata = wd; x.strb = st;
      seq.push_back(x);
   endtask

   // Pipelined driver: address phase k overlaps the data phase of k-1.
   task automatic run_seq(input int s);
      int n, len;
      bit rd_last;
      xfer_t p;
      n = seq.size();
      seq_low = 0;
      seq_rdata_last = '0;
      d_sel = (s != 0);
      for (int k = 0; k <= n; k++) begin
         len = (k == 0) ? 1 : plen(s, seq[k-1]);
         for (int j = 1; j <= len; j++) begin
            if (k < n) begin
               d_hsel = 1'b1; d_trans = seq[k].tr; d_addr = seq[k].addr;
               d_wr = seq[k].wr; d_size = seq[k].size;
            end else begin
               d_hsel = 1'b0; d_trans = 2'b00;
            end
            need_rdy = 1'b1; need_resp = 1'b0; need_rdata = '0; need_mask = 32'hFFFF_FFFF;
            rd_last = 1'b0;
            d_wdata = '0; d_strb = '0;
            if (k > 0) begin
               p = seq[k-1];
               d_wdata = p.wdata; d_strb = p.strb;
               if (p.tr[1]) begin
                  if (m_err(p.addr, p.size)) begin
                     need_rdy = (j == 2); need_resp = 1'b1;
                  end else begin
                     need_rdy = (j == len);
                     if (j == len && !p.wr) begin
                        need_rdata = m_word(s, p.addr);
                        need_mask  = m_mask(p.addr, p.size);
                        rd_last    = 1'b1;
                     end
                  end
               end
            end
            chk_en = 1'b1;
            @(negedge clk);
            if (!obs_rdy) seq_low++;
            if (rd_last) seq_rdata_last = obs_rdata;
            @(posedge clk); #1;
         end
         if (k > 0) begin
            p = seq[k-1];
            if (p.tr[1] && p.wr && !m_err(p.addr, p.size)) m_write(s, p);
         end
      end
      chk_en = 1'b0; d_hsel = 1'b0; d_trans = 2'b00;
      seq.delete();
   endtask

   logic pre_rdy, r_rdy, r_resp;
   logic [31:0] r_rdata;

   initial begin
      rst_n = 1'b0; d_sel = 1'b0; d_hsel = 1'b0; d_trans = 2'b00; d_addr = '0;
      d_wr = 1'b0; d_size = 3'd2; d_wdata = '0; d_strb = '0;
      repeat (2) @(posedge clk);
      #1;
      lit_check("reset rdy0",   32'(bus0.HREADYOUT), 32'd1);
      lit_check("reset resp0",  32'(bus0.HRESP),     32'd0);
      lit_check("reset rdata0", bus0.HRDATA,         32'd0);
      lit_check("reset rdy1",   32'(bus1.HREADYOUT), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write then pipelined read of the same word.
      push(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF);
      push(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(0);
      lit_check("ws0 rdata", seq_rdata_last, 32'hDEAD_BEEF);
      lit_check("ws0 low cycles", 32'(seq_low), 32'd0);

      // Single byte lane update.
      push(2'b10, 32'h12, 1'b1, 3'd0, 32'h00AB_0000, 4'h4);
      push(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(0);
      lit_check("byte write rdata", seq_rdata_last, 32'hDEAB_BEEF);
      lit_check("model word 0x10", {mb[0][19], mb[0][18], mb[0][17], mb[0][16]}, 32'hDEAB_BEEF);

      // Error cases: out of range, misaligned, oversize, error window; RAM untouched.
      push(2'b10, 32'h1000, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b10, 32'h12, 1'b1, 3'd2, 32'h5555_5555, 4'hF);
      push(2'b10, 32'h2, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b10, 32'h0, 1'b0, 3'd3, 32'h0, 4'h0);
      push(2'b10, 32'hFFFF_0000, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b10, 32'h0FFC, 1'b1, 3'd2, 32'h7777_7777, 4'hF);
      push(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(0);
      lit_check("after errors rdata", seq_rdata_last, 32'hDEAB_BEEF);

      // INCR burst with a BUSY beat, then read back.
      push(2'b10, 32'h20, 1'b1, 3'd2, 32'hA0A0_0001, 4'hF);
      push(2'b11, 32'h24, 1'b1, 3'd2, 32'hA0A0_0002, 4'hF);
      push(2'b01, 32'h28, 1'b1, 3'd2, 32'hBAD0_BAD0, 4'hF);
      push(2'b11, 32'h28, 1'b1, 3'd2, 32'hA0A0_0003, 4'hF);
      push(2'b11, 32'h2C, 1'b1, 3'd2, 32'hA0A0_0004, 4'hF);
      push(2'b10, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b11, 32'h24, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b11, 32'h28, 1'b0, 3'd2, 32'h0, 4'h0);
      push(2'b11, 32'h2C, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(0);
      lit_check("burst last rdata", seq_rdata_last, 32'hA0A0_0004);
      lit_check("model word 0x28", {mb[0][43], mb[0][42], mb[0][41], mb[0][40]}, 32'hA0A0_0003);

      // Three wait states: write, then a read, an IDLE and an error on their own.
      push(2'b10, 32'h30, 1'b1, 3'd2, 32'hCAFE_F00D, 4'hF);
      run_seq(1);
      push(2'b10, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(1);
      lit_check("ws3 read low cycles", 32'(seq_low), 32'd3);
      lit_check("ws3 read rdata", seq_rdata_last, 32'hCAFE_F00D);
      push(2'b00, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(1);
      lit_check("ws3 idle low cycles", 32'(seq_low), 32'd0);
      push(2'b10, 32'h1000, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(1);
      lit_check("ws3 error low cycles", 32'(seq_low), 32'd1);

      // Reset in the middle of a waited write drops the write.
      push(2'b10, 32'h40, 1'b1, 3'd2, 32'h1111_1111, 4'hF);
      run_seq(1);
      d_sel = 1'b1; d_hsel = 1'b1; d_trans = 2'b10; d_addr = 32'h40; d_wr = 1'b1; d_size = 3'd2;
      @(posedge clk); #1;
      d_hsel = 1'b0; d_trans = 2'b00; d_wdata = 32'h9999_9999; d_strb = 4'hF;
      @(posedge clk); #1;
      pre_rdy = bus1.HREADYOUT;
      rst_n = 1'b0;
      #1;
      r_rdy = bus1.HREADYOUT; r_resp = bus1.HRESP; r_rdata = bus1.HRDATA;
      lit_check("pre-reset wait rdy", 32'(pre_rdy), 32'd0);
      lit_check("async reset rdy", 32'(r_rdy), 32'd1);
      lit_check("async reset resp", 32'(r_resp), 32'd0);
      lit_check("async reset rdata", r_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      push(2'b10, 32'h40, 1'b0, 3'd2, 32'h0, 4'h0);
      run_seq(1);
      lit_check("aborted write rdata", seq_rdata_last, 32'h1111_1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
